tag_pool: RTL

TAG_POOL -- requirements
Module: tag_pool

---
 rtl/math_pkg.sv | 8 +
 rtl/tag_pool_pkg.sv | 20 ++
 rtl/e.sv | 58 +++++
 rtl/tag_pool.sv | 102 ++++++++++
 4 files changed

// File: rtl/math_pkg.sv
// Shared arithmetic helpers for elaboration-time sizing.
package math_pkg;

  function automatic int div_ceil(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/tag_pool_pkg.sv
// Sizing helpers and types shared by the tag pool and its users.
package tag_pool_pkg;

  localparam int POOL_W = 32;

  function automatic int tag_bits(input int w);
    return $clog2(w);
  endfunction

  function automatic int cnt_bits(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int TAG_W = tag_bits(POOL_W);
  localparam int CNT_W = cnt_bits(POOL_W);

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/e.sv
// Circular leftmost-zero finder: first zero of x scanning pos-1 downward,
// wrapping to W-1 and ending at pos. Two-level search in groups of RADIX_N.
module e
  import math_pkg::*;
#(
  parameter int W       = 32,
  parameter int RADIX_N = 4
) (
  input  logic [W-1:0]         x,
  input  logic [$clog2(W)-1:0] pos,
  output logic [$clog2(W)-1:0] idx,
  output logic                 any
);

  localparam int TW = $clog2(W);
  localparam int NG = div_ceil(W, RADIX_N);
  localparam int PW = NG * RADIX_N;

  // Returns {found, index of the highest zero}; padding bits are ones.
  function automatic logic [TW:0] find_lz(input logic [PW-1:0] v);
    int   g_sel;
    int   b_sel;
    logic g_any;
    g_any = 1'b0;
    g_sel = 0;
    b_sel = 0;
    for (int g = 0; g < NG; g++) begin
      if (!(&v[g*RADIX_N +: RADIX_N])) begin
        g_any = 1'b1;
        g_sel = g;
      end
    end
    for (int b = 0; b < RADIX_N; b++) begin
      if (!v[g_sel*RADIX_N + b]) b_sel = b;
    end
    return {g_any, TW'(g_sel * RADIX_N + b_sel)};
  endfunction

  logic [PW-1:0] x_full;
  logic [PW-1:0] x_low;
  logic [TW:0]   r_full;
  logic [TW:0]   r_low;

  // Positions below pos are searched first; only if none is free do we wrap.
  always_comb begin
    x_full        = '1;
    x_full[W-1:0] = x;
    x_low         = x_full;
    for (int i = 0; i < W; i++) begin
      if (i >= int'(pos)) x_low[i] = 1'b1;
    end
    r_full = find_lz(x_full);
    r_low  = find_lz(x_low);
    any    = r_full[TW];
    idx    = r_low[TW] ? r_low[TW-1:0] : r_full[TW-1:0];
  end

endmodule

// File: rtl/tag_pool.sv
// Tag allocator: offers a registered free tag per cycle, accepts releases,
// tracks free count and flags releases of tags that are not allocated.
module tag_pool
  import tag_pool_pkg::*;
#(
  parameter int W       = 32,
  parameter int RADIX_N = 4
) (
  input  logic                   clk,
  input  logic                   arst_n,
  output logic                   alloc_vld_o,
  output logic [$clog2(W)-1:0]   alloc_tag_o,
  input  logic                   alloc_rdy_i,
  input  logic                   rel_vld_i,
  input  logic [$clog2(W)-1:0]   rel_tag_i,
  input  logic                   flush_i,
  output logic [$clog2(W+1)-1:0] free_cnt_o,
  output logic                   full_o,
  output logic                   err_o
);

  localparam int TW = tag_bits(W);
  localparam int CW = cnt_bits(W);

  logic [W-1:0]  occ_q, occ_d;
  logic [TW-1:0] ptr_q, ptr_d;
  logic          alloc_vld_q, alloc_vld_d;
  logic [TW-1:0] alloc_tag_q, alloc_tag_d;
  logic [CW-1:0] free_cnt_q, free_cnt_d;
  logic          err_q, err_d;

  logic          alloc_fire;
  logic          rel_ok;
  logic [TW-1:0] srch_idx;
  logic          srch_any;
  int            ones;

  always_comb begin
    occ_d      = occ_q;
    ptr_d      = ptr_q;
    err_d      = err_q;
    alloc_fire = alloc_vld_q & alloc_rdy_i;
    rel_ok     = 1'b0;
    if (int'(rel_tag_i) < W) rel_ok = occ_q[rel_tag_i];

    if (flush_i) begin
      occ_d = '0;
      ptr_d = '0;
    end else begin
      if (alloc_fire) begin
        occ_d[alloc_tag_q] = 1'b1;
        ptr_d              = alloc_tag_q;
      end
      // A release of a free tag (even the one being accepted) leaves occupancy alone.
      if (rel_vld_i) begin
        if (rel_ok) occ_d[rel_tag_i] = 1'b0;
        else        err_d            = 1'b1;
      end
    end

    ones = 0;
    for (int i = 0; i < W; i++) ones += int'(occ_d[i]);
    free_cnt_d  = CW'(W - ones);
    alloc_vld_d = srch_any;
    alloc_tag_d = srch_idx;
  end

  e #(
    .W       (W),
    .RADIX_N (RADIX_N)
  ) u_find (
    .x   (occ_d),
    .pos (ptr_d),
    .idx (srch_idx),
    .any (srch_any)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      occ_q       <= '0;
      ptr_q       <= '0;
      alloc_vld_q <= 1'b0;
      alloc_tag_q <= '0;
      free_cnt_q  <= CW'(W);
      err_q       <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      ptr_q       <= ptr_d;
      alloc_vld_q <= alloc_vld_d;
      alloc_tag_q <= alloc_tag_d;
      free_cnt_q  <= free_cnt_d;
      err_q       <= err_d;
    end
  end

  assign alloc_vld_o = alloc_vld_q;
  assign alloc_tag_o = alloc_tag_q;
  assign free_cnt_o  = free_cnt_q;
  assign full_o      = (free_cnt_q == '0);
  assign err_o       = err_q;

endmodule
